// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: evaluates branch conditions,
// issues a registered fetch redirect, flushes IF/ID, counts outcomes.
module branch_resolve_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  br_valid,
  input  logic [2:0]            br_funct3,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic [DATA_WIDTH-1:0] br_pc,
  input  logic [DATA_WIDTH-1:0] br_imm,
  input  logic                  redirect_ready,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  flush,
  output logic                  busy,
  output logic                  illegal_br,
  output logic [CNT_WIDTH-1:0]  taken_cnt,
  output logic [CNT_WIDTH-1:0]  not_taken_cnt
);

  localparam int FCW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    sIdle,
    sRedirect,
    sFlush
  } state_t;

  state_t state;
  logic [FCW-1:0] flushCnt;

  logic isEq;
  logic isLtS;
  logic isLtU;
  logic takenCond;
  logic isIllegal;
  logic [DATA_WIDTH-1:0] target;

  assign isEq   = (SrcA == SrcB);
  assign isLtS  = ($signed(SrcA) < $signed(SrcB));
  assign isLtU  = (SrcA < SrcB);
  assign target = br_pc + br_imm;

  // Decode funct3 into a taken decision or an illegal encoding
  always_comb begin
    takenCond = 1'b0;
    isIllegal = 1'b0;
    case (br_funct3)
      3'b000:  takenCond = isEq;
      3'b001:  takenCond = ~isEq;
      3'b100:  takenCond = isLtS;
      3'b101:  takenCond = ~isLtS;
      3'b110:  takenCond = isLtU;
      3'b111:  takenCond = ~isLtU;
      default: isIllegal = 1'b1;
    endcase
  end

  // Redirect/flush FSM with registered outputs and saturating counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= sIdle;
      flushCnt       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      busy           <= 1'b0;
      illegal_br     <= 1'b0;
      taken_cnt      <= '0;
      not_taken_cnt  <= '0;
    end else begin
      illegal_br <= 1'b0;
      case (state)
        sIdle: begin
          if (br_valid) begin
            if (isIllegal) begin
              illegal_br <= 1'b1;
            end else if (takenCond) begin
              redirect_pc    <= target;
              redirect_valid <= 1'b1;
              flush          <= 1'b1;
              busy           <= 1'b1;
              state          <= sRedirect;
              if (taken_cnt != '1)
                taken_cnt <= taken_cnt + 1'b1;
            end else begin
              if (not_taken_cnt != '1)
                not_taken_cnt <= not_taken_cnt + 1'b1;
            end
          end
        end
        sRedirect: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            flushCnt       <= FCW'(FLUSH_CYCLES);
            state          <= sFlush;
          end
        end
        sFlush: begin
          if (flushCnt <= FCW'(1)) begin
            flush <= 1'b0;
            busy  <= 1'b0;
            state <= sIdle;
          end else begin
            flushCnt <= flushCnt - 1'b1;
          end
        end
        default: begin
          redirect_valid <= 1'b0;
          flush          <= 1'b0;
          busy           <= 1'b0;
          state          <= sIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit.
// Inputs change 1ns after posedge; outputs checked there too.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        br_valid;
  logic [2:0]  br_funct3;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [31:0] br_pc;
  logic [31:0] br_imm;
  logic        redirect_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        busy;
  logic        illegal_br;
  logic [15:0] taken_cnt;
  logic [15:0] not_taken_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk           (clk),
    .reset         (reset),
    .br_valid      (br_valid),
    .br_funct3     (br_funct3),
    .SrcA          (SrcA),
    .SrcB          (SrcB),
    .br_pc         (br_pc),
    .br_imm        (br_imm),
    .redirect_ready(redirect_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .flush         (flush),
    .busy          (busy),
    .illegal_br    (illegal_br),
    .taken_cnt     (taken_cnt),
    .not_taken_cnt (not_taken_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chkCtl(input string tag,
                        input logic rv, input logic fl,
                        input logic bz);
    chk({tag, "_rv"}, {31'b0, redirect_valid}, {31'b0, rv});
    chk({tag, "_fl"}, {31'b0, flush}, {31'b0, fl});
    chk({tag, "_bz"}, {31'b0, busy}, {31'b0, bz});
  endtask

  task automatic chkCnt(input string tag,
                        input int tk, input int nt);
    chk({tag, "_tk"}, {16'b0, taken_cnt}, tk);
    chk({tag, "_nt"}, {16'b0, not_taken_cnt}, nt);
  endtask

  initial begin
    reset = 1'b1;
    br_valid = 1'b0;
    br_funct3 = 3'b000;
    SrcA = '0;
    SrcB = '0;
    br_pc = '0;
    br_imm = '0;
    redirect_ready = 1'b0;
    #1;
    step();
    chkCtl("rst", 0, 0, 0);
    chk("rst_ill", {31'b0, illegal_br}, 0);
    chk("rst_pc", redirect_pc, 0);
    chkCnt("rst", 0, 0);
    reset = 1'b0;

    // BLT -1 < 1 signed: taken, ready tied high
    br_valid = 1'b1;
    br_funct3 = 3'b100;
    SrcA = 32'hFFFF_FFFF;
    SrcB = 32'h0000_0001;
    br_pc = 32'h100;
    br_imm = 32'h20;
    redirect_ready = 1'b1;
    step();
    br_valid = 1'b0;
    chkCtl("blt1", 1, 1, 1);
    chk("blt_pc", redirect_pc, 32'h120);
    chkCnt("blt", 1, 0);
    step();
    chkCtl("blt2", 0, 1, 1);
    step();
    chkCtl("blt3", 0, 1, 1);
    step();
    chkCtl("blt4", 0, 0, 0);

    // BLTU not taken, then BGEU taken back-to-back
    br_valid = 1'b1;
    br_funct3 = 3'b110;
    step();
    chkCtl("bltu", 0, 0, 0);
    chkCnt("bltu", 1, 1);
    br_funct3 = 3'b111;
    step();
    br_valid = 1'b0;
    chkCtl("bgeu", 1, 1, 1);
    chkCnt("bgeu", 2, 1);
    step();
    step();
    step();
    chkCtl("bgeu_end", 0, 0, 0);

    // BEQ with target wrap-around
    br_valid = 1'b1;
    br_funct3 = 3'b000;
    SrcA = 32'hA;
    SrcB = 32'hA;
    br_pc = 32'hFFFF_FFFC;
    br_imm = 32'h8;
    step();
    br_valid = 1'b0;
    chk("beq_pc", redirect_pc, 32'h4);
    chkCnt("beq", 3, 1);
    step();
    step();
    step();
    chkCtl("beq_end", 0, 0, 0);

    // BNE under backpressure, wrong-path br_valid ignored
    redirect_ready = 1'b0;
    br_valid = 1'b1;
    br_funct3 = 3'b001;
    SrcA = 32'h1;
    SrcB = 32'h2;
    br_pc = 32'h200;
    br_imm = 32'hFFFF_FFF0;
    step();
    br_valid = 1'b0;
    br_pc = 32'h999;
    for (int i = 0; i < 4; i++) begin
      chkCtl($sformatf("bp%0d", i), 1, 1, 1);
      chk($sformatf("bp%0d_pc", i), redirect_pc, 32'h1F0);
      br_valid = (i == 1);
      step();
      br_valid = 1'b0;
    end
    chkCnt("bp", 4, 1);
    chk("bp_ill", {31'b0, illegal_br}, 0);
    redirect_ready = 1'b1;
    step();
    chkCtl("bp_acc", 0, 1, 1);
    step();
    chkCtl("bp_f2", 0, 1, 1);
    step();
    chkCtl("bp_end", 0, 0, 0);

    // illegal funct3 011
    br_valid = 1'b1;
    br_funct3 = 3'b011;
    step();
    br_valid = 1'b0;
    chk("ill_on", {31'b0, illegal_br}, 1);
    chkCtl("ill", 0, 0, 0);
    chkCnt("ill", 4, 1);
    step();
    chk("ill_off", {31'b0, illegal_br}, 0);

    // reset while redirect pending
    redirect_ready = 1'b0;
    br_valid = 1'b1;
    br_funct3 = 3'b000;
    SrcA = 32'h7;
    SrcB = 32'h7;
    br_pc = 32'h40;
    br_imm = 32'h4;
    step();
    br_valid = 1'b0;
    chkCtl("pre_rst", 1, 1, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chkCtl("mrst", 0, 0, 0);
    chk("mrst_pc", redirect_pc, 0);
    chkCnt("mrst", 0, 0);

    // BGE 5 >= 10 false: not taken
    br_valid = 1'b1;
    br_funct3 = 3'b101;
    SrcA = 32'd5;
    SrcB = 32'd10;
    step();
    br_valid = 1'b0;
    chkCtl("bge", 0, 0, 0);
    chkCnt("bge", 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
